// File: rtl/tl_rx_fc_pkg.sv
// Shared type codes, error causes and scaled-FC field-width helpers for the
// TL RX flow-control credit checker.
package tl_rx_fc_pkg;

    localparam int unsigned NUM_TYP = 3;

    typedef enum logic [1:0] {
        TYP_P    = 2'b00,
        TYP_NP   = 2'b01,
        TYP_CPL  = 2'b10,
        TYP_RSVD = 2'b11
    } fc_typ_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_HDR    = 2'b01,
        CAUSE_DATA   = 2'b10,
        CAUSE_UNINIT = 2'b11
    } fc_cause_e;

    function automatic int unsigned hdr_field_w(input logic [1:0] scale);
        case (scale)
            2'b10:   return 10;
            2'b11:   return 12;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned data_field_w(input logic [1:0] scale);
        case (scale)
            2'b10:   return 14;
            2'b11:   return 16;
            default: return 12;
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/tl_rx_fc_credit_slot.sv
// One VC/type credit slot: header and data ALLOC/RCVD counter pairs with
// modular overflow detection for the next TLP.
module tl_rx_fc_credit_slot
    import tl_rx_fc_pkg::*;
#(
    parameter int unsigned HDR_W  = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CONS_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_en,
    input  logic [HDR_W-1:0]  init_hdr,
    input  logic [DATA_W-1:0] init_data,
    input  logic [1:0]        init_hdr_scale,
    input  logic [1:0]        init_data_scale,
    input  logic              rel_en,
    input  logic [HDR_W-1:0]  rel_hdr,
    input  logic [DATA_W-1:0] rel_data,
    input  logic              cons_en,
    input  logic [CONS_W-1:0] cons_data,
    output logic              init_flag,
    output logic              hdr_ovf,
    output logic              data_ovf
);

    logic [HDR_W-1:0]  hdr_alloc_q, hdr_alloc_d, hdr_rcvd_q, hdr_rcvd_d;
    logic [DATA_W-1:0] data_alloc_q, data_alloc_d, data_rcvd_q, data_rcvd_d;
    logic [1:0]        hdr_scale_q, hdr_scale_d, data_scale_q, data_scale_d;
    logic              hdr_inf_q, hdr_inf_d, data_inf_q, data_inf_d;
    logic              init_q, init_d;

    logic [HDR_W-1:0]  hdr_mask, hdr_msb, hdr_new_rcvd, hdr_diff, init_hdr_mask;
    logic [DATA_W-1:0] data_mask, data_msb, data_new_rcvd, data_diff, init_data_mask;

    // Overflow test: (ALLOC - (RCVD + consumed)) mod 2^W lands in the upper half.
    always_comb begin
        hdr_mask       = HDR_W'(field_mask(hdr_field_w(hdr_scale_q)));
        data_mask      = DATA_W'(field_mask(data_field_w(data_scale_q)));
        init_hdr_mask  = HDR_W'(field_mask(hdr_field_w(init_hdr_scale)));
        init_data_mask = DATA_W'(field_mask(data_field_w(init_data_scale)));
        hdr_msb        = hdr_mask ^ (hdr_mask >> 1);
        data_msb       = data_mask ^ (data_mask >> 1);

        hdr_new_rcvd   = (hdr_rcvd_q + HDR_W'(1)) & hdr_mask;
        hdr_diff       = (hdr_alloc_q - hdr_new_rcvd) & hdr_mask;
        data_new_rcvd  = (data_rcvd_q + DATA_W'(cons_data)) & data_mask;
        data_diff      = (data_alloc_q - data_new_rcvd) & data_mask;

        hdr_ovf        = !hdr_inf_q && ((hdr_diff & hdr_msb) != '0);
        data_ovf       = !data_inf_q && ((data_diff & data_msb) != '0);
        init_flag      = init_q;
    end

    always_comb begin
        hdr_alloc_d  = hdr_alloc_q;
        hdr_rcvd_d   = hdr_rcvd_q;
        data_alloc_d = data_alloc_q;
        data_rcvd_d  = data_rcvd_q;
        hdr_scale_d  = hdr_scale_q;
        data_scale_d = data_scale_q;
        hdr_inf_d    = hdr_inf_q;
        data_inf_d   = data_inf_q;
        init_d       = init_q;

        if (init_en) begin
            hdr_alloc_d  = init_hdr & init_hdr_mask;
            data_alloc_d = init_data & init_data_mask;
            hdr_rcvd_d   = '0;
            data_rcvd_d  = '0;
            hdr_scale_d  = init_hdr_scale;
            data_scale_d = init_data_scale;
            hdr_inf_d    = (init_hdr == '0);
            data_inf_d   = (init_data == '0);
            init_d       = 1'b1;
        end else begin
            if (rel_en && init_q) begin
                if (!hdr_inf_q)  hdr_alloc_d  = (hdr_alloc_q + rel_hdr) & hdr_mask;
                if (!data_inf_q) data_alloc_d = (data_alloc_q + rel_data) & data_mask;
            end
            if (cons_en && init_q) begin
                if (!hdr_inf_q)  hdr_rcvd_d  = hdr_new_rcvd;
                if (!data_inf_q) data_rcvd_d = data_new_rcvd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_alloc_q  <= '0;
            hdr_rcvd_q   <= '0;
            data_alloc_q <= '0;
            data_rcvd_q  <= '0;
            hdr_scale_q  <= '0;
            data_scale_q <= '0;
            hdr_inf_q    <= 1'b0;
            data_inf_q   <= 1'b0;
            init_q       <= 1'b0;
        end else begin
            hdr_alloc_q  <= hdr_alloc_d;
            hdr_rcvd_q   <= hdr_rcvd_d;
            data_alloc_q <= data_alloc_d;
            data_rcvd_q  <= data_rcvd_d;
            hdr_scale_q  <= hdr_scale_d;
            data_scale_q <= data_scale_d;
            hdr_inf_q    <= hdr_inf_d;
            data_inf_q   <= data_inf_d;
            init_q       <= init_d;
        end
    end

endmodule

// File: rtl/tl_rx_fc_credit_checker.sv
// Multi-VC receiver flow-control checker: decodes init/release/TLP events onto
// per-VC/type credit slots, prioritises collisions and captures the first error.
module tl_rx_fc_credit_checker
    import tl_rx_fc_pkg::*;
#(
    parameter int unsigned NUM_VC              = 2,
    parameter int unsigned VC_W                = 1,
    parameter int unsigned FC_HDR_CREDS_WIDTH  = 12,
    parameter int unsigned FC_DATA_CREDS_WIDTH = 16,
    parameter int unsigned CONS_DATA_WIDTH     = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init_valid,
    input  logic [VC_W-1:0]                init_vc,
    input  logic [1:0]                     init_typ,
    input  logic [FC_HDR_CREDS_WIDTH-1:0]  init_hdr_creds,
    input  logic [FC_DATA_CREDS_WIDTH-1:0] init_data_creds,
    input  logic [1:0]                     init_hdr_scale,
    input  logic [1:0]                     init_data_scale,
    input  logic                           release_valid,
    input  logic [VC_W-1:0]                release_vc,
    input  logic [1:0]                     release_typ,
    input  logic [FC_HDR_CREDS_WIDTH-1:0]  release_hdr_creds,
    input  logic [FC_DATA_CREDS_WIDTH-1:0] release_data_creds,
    input  logic                           tlp_valid,
    input  logic [VC_W-1:0]                tlp_vc,
    input  logic [1:0]                     tlp_typ,
    input  logic [CONS_DATA_WIDTH-1:0]     tlp_data_creds,
    input  logic                           flow_control_en,
    output logic                           flow_control_error,
    output logic                           err_sticky,
    output logic [VC_W-1:0]                err_vc,
    output logic [1:0]                     err_typ,
    output logic [1:0]                     err_cause,
    output logic [NUM_VC-1:0]              vc_active
);

    localparam int unsigned NSLOT = NUM_VC * NUM_TYP;

    logic [NSLOT-1:0] slot_init_en, slot_rel_en, slot_cons_en, slot_tlp_hit;
    logic [NSLOT-1:0] slot_init_flag, slot_hdr_ovf, slot_data_ovf, init_next;

    logic              sel_init, sel_hdr_ovf, sel_data_ovf, sel_collide;
    logic              tlp_live, tlp_err;
    fc_cause_e         cause;

    logic              pulse_q, pulse_d;
    logic              sticky_q, sticky_d;
    logic [VC_W-1:0]   err_vc_q, err_vc_d;
    logic [1:0]        err_typ_q, err_typ_d;
    logic [1:0]        err_cause_q, err_cause_d;
    logic [NUM_VC-1:0] vc_active_q, vc_active_d;

    // An init on a slot wins; a release or TLP aimed at that same slot is dropped.
    always_comb begin
        slot_init_en = '0;
        slot_rel_en  = '0;
        slot_tlp_hit = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            for (int unsigned t = 0; t < NUM_TYP; t++) begin
                slot_init_en[v*NUM_TYP+t] = init_valid && (init_vc == VC_W'(v)) &&
                                            (init_typ == 2'(t));
                slot_rel_en[v*NUM_TYP+t]  = release_valid && (release_vc == VC_W'(v)) &&
                                            (release_typ == 2'(t)) &&
                                            !slot_init_en[v*NUM_TYP+t];
                slot_tlp_hit[v*NUM_TYP+t] = (tlp_vc == VC_W'(v)) && (tlp_typ == 2'(t));
            end
        end
    end

    always_comb begin
        sel_init     = 1'b0;
        sel_hdr_ovf  = 1'b0;
        sel_data_ovf = 1'b0;
        sel_collide  = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (slot_tlp_hit[i]) begin
                sel_init     = slot_init_flag[i];
                sel_hdr_ovf  = slot_hdr_ovf[i];
                sel_data_ovf = slot_data_ovf[i];
                sel_collide  = slot_init_en[i];
            end
        end

        tlp_live = tlp_valid && (tlp_typ != TYP_RSVD) && !sel_collide;

        if (!sel_init)         cause = CAUSE_UNINIT;
        else if (sel_data_ovf) cause = CAUSE_DATA;
        else if (sel_hdr_ovf)  cause = CAUSE_HDR;
        else                   cause = CAUSE_NONE;
        tlp_err = (cause != CAUSE_NONE);

        // Erroneous TLPs are discarded only while error reporting is enabled.
        slot_cons_en = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            slot_cons_en[i] = slot_tlp_hit[i] && tlp_live && sel_init &&
                              (!tlp_err || !flow_control_en);
        end
    end

    always_comb begin
        pulse_d     = tlp_live && tlp_err && flow_control_en;
        sticky_d    = sticky_q | pulse_d;
        err_vc_d    = err_vc_q;
        err_typ_d   = err_typ_q;
        err_cause_d = err_cause_q;
        if (pulse_d && !sticky_q) begin
            err_vc_d    = tlp_vc;
            err_typ_d   = tlp_typ;
            err_cause_d = cause;
        end

        init_next = slot_init_flag | slot_init_en;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            vc_active_d[v] = init_next[v*NUM_TYP] & init_next[v*NUM_TYP+1] &
                             init_next[v*NUM_TYP+2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q     <= 1'b0;
            sticky_q    <= 1'b0;
            err_vc_q    <= '0;
            err_typ_q   <= '0;
            err_cause_q <= '0;
            vc_active_q <= '0;
        end else begin
            pulse_q     <= pulse_d;
            sticky_q    <= sticky_d;
            err_vc_q    <= err_vc_d;
            err_typ_q   <= err_typ_d;
            err_cause_q <= err_cause_d;
            vc_active_q <= vc_active_d;
        end
    end

    assign flow_control_error = pulse_q;
    assign err_sticky         = sticky_q;
    assign err_vc             = err_vc_q;
    assign err_typ            = err_typ_q;
    assign err_cause          = err_cause_q;
    assign vc_active          = vc_active_q;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        tl_rx_fc_credit_slot #(
            .HDR_W  (FC_HDR_CREDS_WIDTH),
            .DATA_W (FC_DATA_CREDS_WIDTH),
            .CONS_W (CONS_DATA_WIDTH)
        ) u_slot (
            .clk             (clk),
            .rst_n           (rst_n),
            .init_en         (slot_init_en[g]),
            .init_hdr        (init_hdr_creds),
            .init_data       (init_data_creds),
            .init_hdr_scale  (init_hdr_scale),
            .init_data_scale (init_data_scale),
            .rel_en          (slot_rel_en[g]),
            .rel_hdr         (release_hdr_creds),
            .rel_data        (release_data_creds),
            .cons_en         (slot_cons_en[g]),
            .cons_data       (tlp_data_creds),
            .init_flag       (slot_init_flag[g]),
            .hdr_ovf         (slot_hdr_ovf[g]),
            .data_ovf        (slot_data_ovf[g])
        );
    end

endmodule

// File: tb/tb_tl_rx_fc_credit_checker.sv
// Scoreboard bench for tl_rx_fc_credit_checker: directed scenarios plus random
// traffic checked against an arithmetic credit model.
module tb_tl_rx_fc_credit_checker;

    localparam int NUM_VC = 2;
    localparam int VC_W   = 1;
    localparam int HW     = 12;
    localparam int DW     = 16;
    localparam int CW     = 9;
    localparam int NSLOT  = NUM_VC * 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_valid;
    logic [VC_W-1:0]   init_vc;
    logic [1:0]        init_typ;
    logic [HW-1:0]     init_hdr_creds;
    logic [DW-1:0]     init_data_creds;
    logic [1:0]        init_hdr_scale;
    logic [1:0]        init_data_scale;
    logic              release_valid;
    logic [VC_W-1:0]   release_vc;
    logic [1:0]        release_typ;
    logic [HW-1:0]     release_hdr_creds;
    logic [DW-1:0]     release_data_creds;
    logic              tlp_valid;
    logic [VC_W-1:0]   tlp_vc;
    logic [1:0]        tlp_typ;
    logic [CW-1:0]     tlp_data_creds;
    logic              flow_control_en;
    logic              flow_control_error;
    logic              err_sticky;
    logic [VC_W-1:0]   err_vc;
    logic [1:0]        err_typ;
    logic [1:0]        err_cause;
    logic [NUM_VC-1:0] vc_active;

    tl_rx_fc_credit_checker #(
        .NUM_VC              (NUM_VC),
        .VC_W                (VC_W),
        .FC_HDR_CREDS_WIDTH  (HW),
        .FC_DATA_CREDS_WIDTH (DW),
        .CONS_DATA_WIDTH     (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .init_valid         (init_valid),
        .init_vc            (init_vc),
        .init_typ           (init_typ),
        .init_hdr_creds     (init_hdr_creds),
        .init_data_creds    (init_data_creds),
        .init_hdr_scale     (init_hdr_scale),
        .init_data_scale    (init_data_scale),
        .release_valid      (release_valid),
        .release_vc         (release_vc),
        .release_typ        (release_typ),
        .release_hdr_creds  (release_hdr_creds),
        .release_data_creds (release_data_creds),
        .tlp_valid          (tlp_valid),
        .tlp_vc             (tlp_vc),
        .tlp_typ            (tlp_typ),
        .tlp_data_creds     (tlp_data_creds),
        .flow_control_en    (flow_control_en),
        .flow_control_error (flow_control_error),
        .err_sticky         (err_sticky),
        .err_vc             (err_vc),
        .err_typ            (err_typ),
        .err_cause          (err_cause),
        .vc_active          (vc_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pulse;
        bit          sticky;
        int unsigned evc;
        int unsigned etyp;
        int unsigned ecause;
        int unsigned vact;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: plain integers per slot, slot = vc*3 + type.
    int unsigned m_ha[NSLOT], m_hr[NSLOT], m_da[NSLOT], m_dr[NSLOT];
    int unsigned m_hw[NSLOT], m_dw[NSLOT];
    bit          m_hi[NSLOT], m_di[NSLOT], m_in[NSLOT];
    bit          m_sticky;
    int unsigned m_evc, m_etyp, m_ecause;

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int unsigned wrap(longint v, int unsigned w);
        longint p = longint'(1) << w;
        return int'(((v % p) + p) % p);
    endfunction

    function automatic bit over(int unsigned alloc, int unsigned new_rcvd, int unsigned w);
        int unsigned diff = wrap(longint'(alloc) - longint'(new_rcvd), w);
        return diff >= (32'd1 << (w - 1));
    endfunction

    function automatic int unsigned hw_of(int unsigned s);
        return (s == 3) ? 12 : (s == 2) ? 10 : 8;
    endfunction

    function automatic int unsigned dw_of(int unsigned s);
        return (s == 3) ? 16 : (s == 2) ? 14 : 12;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            m_ha[i] = 0; m_hr[i] = 0; m_da[i] = 0; m_dr[i] = 0;
            m_hw[i] = 8; m_dw[i] = 12;
            m_hi[i] = 0; m_di[i] = 0; m_in[i] = 0;
        end
        m_sticky = 0; m_evc = 0; m_etyp = 0; m_ecause = 0;
    endtask

    task automatic model_step();
        exp_t        e;
        bit          pulse = 0;
        int unsigned ts, rs, is, cause, nh, nd, vact;
        bit          hov, dov;
        ts = 32'(tlp_vc) * 3 + 32'(tlp_typ);
        rs = 32'(release_vc) * 3 + 32'(release_typ);
        is = 32'(init_vc) * 3 + 32'(init_typ);

        if (tlp_valid && tlp_typ != 2'b11 && !(init_valid && init_vc == tlp_vc && init_typ == tlp_typ)) begin
            nh = m_hr[ts] + 1;
            nd = m_dr[ts] + 32'(tlp_data_creds);
            if (!m_in[ts]) cause = 3;
            else begin
                hov   = !m_hi[ts] && over(m_ha[ts], wrap(nh, m_hw[ts]), m_hw[ts]);
                dov   = !m_di[ts] && over(m_da[ts], wrap(nd, m_dw[ts]), m_dw[ts]);
                cause = dov ? 2 : (hov ? 1 : 0);
            end
            if (cause != 0 && flow_control_en) begin
                pulse = 1;
                if (!m_sticky) begin
                    m_sticky = 1; m_evc = 32'(tlp_vc); m_etyp = 32'(tlp_typ); m_ecause = cause;
                end
            end else if (m_in[ts]) begin
                if (!m_hi[ts]) m_hr[ts] = wrap(nh, m_hw[ts]);
                if (!m_di[ts]) m_dr[ts] = wrap(nd, m_dw[ts]);
            end
        end

        if (release_valid && release_typ != 2'b11 && m_in[rs] &&
            !(init_valid && init_vc == release_vc && init_typ == release_typ)) begin
            if (!m_hi[rs]) m_ha[rs] = wrap(longint'(m_ha[rs]) + longint'(release_hdr_creds), m_hw[rs]);
            if (!m_di[rs]) m_da[rs] = wrap(longint'(m_da[rs]) + longint'(release_data_creds), m_dw[rs]);
        end

        if (init_valid && init_typ != 2'b11) begin
            m_hw[is] = hw_of(32'(init_hdr_scale));
            m_dw[is] = dw_of(32'(init_data_scale));
            m_ha[is] = wrap(longint'(init_hdr_creds), m_hw[is]);
            m_da[is] = wrap(longint'(init_data_creds), m_dw[is]);
            m_hr[is] = 0; m_dr[is] = 0;
            m_hi[is] = (init_hdr_creds == 0);
            m_di[is] = (init_data_creds == 0);
            m_in[is] = 1;
        end

        vact = 0;
        for (int v = 0; v < NUM_VC; v++)
            if (m_in[v*3] && m_in[v*3+1] && m_in[v*3+2]) vact |= (32'd1 << v);

        e.pulse = pulse; e.sticky = m_sticky; e.evc = m_evc;
        e.etyp = m_etyp; e.ecause = m_ecause; e.vact = vact;
        exp_q.push_back(e);
    endtask

    task automatic clear_in();
        init_valid = 0; init_vc = '0; init_typ = '0; init_hdr_creds = '0; init_data_creds = '0;
        init_hdr_scale = '0; init_data_scale = '0;
        release_valid = 0; release_vc = '0; release_typ = '0;
        release_hdr_creds = '0; release_data_creds = '0;
        tlp_valid = 0; tlp_vc = '0; tlp_typ = '0; tlp_data_creds = '0;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        clear_in();
    endtask

    task automatic do_init(int vc, int typ, int h, int d, int hs, int ds);
        init_valid = 1; init_vc = VC_W'(vc); init_typ = 2'(typ);
        init_hdr_creds = HW'(h); init_data_creds = DW'(d);
        init_hdr_scale = 2'(hs); init_data_scale = 2'(ds);
        tick();
    endtask

    task automatic do_tlp(int vc, int typ, int d);
        tlp_valid = 1; tlp_vc = VC_W'(vc); tlp_typ = 2'(typ); tlp_data_creds = CW'(d);
        tick();
    endtask

    task automatic do_rel(int vc, int typ, int h, int d);
        release_valid = 1; release_vc = VC_W'(vc); release_typ = 2'(typ);
        release_hdr_creds = HW'(h); release_data_creds = DW'(d);
        tick();
    endtask

    // Asserted between edges so the outputs must clear with no clock.
    task automatic do_reset();
        #2 rst_n = 0;
        #1 chk("async_reset_outputs",
               {flow_control_error, err_sticky, err_vc, err_typ, err_cause, vc_active}, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: one expected record per issued cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("flow_control_error", 32'(flow_control_error), 32'(e.pulse));
                chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
                chk("vc_active", 32'(vc_active), e.vact);
                if (e.sticky) begin
                    chk("err_vc", 32'(err_vc), e.evc);
                    chk("err_typ", 32'(err_typ), e.etyp);
                    chk("err_cause", 32'(err_cause), e.ecause);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_in();
        flow_control_en = 1;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {flow_control_error, err_sticky, err_vc, err_typ, err_cause, vc_active}, 0);
        rst_n = 1;
        @(negedge clk);

        // TLP to an uninitialised slot.
        do_tlp(0, 0, 0);

        // Header limit on VC1/P; erroneous TLPs do not consume.
        do_init(1, 0, 4, 16, 1, 1);
        repeat (4) do_tlp(1, 0, 4);
        do_tlp(1, 0, 0);
        do_tlp(1, 0, 0);

        // Infinite header credits on VC1/NP.
        do_init(1, 1, 0, 8, 0, 0);
        repeat (100) do_tlp(1, 1, 0);

        // 16-bit data wrap-around on VC1/CPL; completes vc_active[1].
        do_init(1, 2, 0, 16'h0010, 3, 3);
        for (int i = 0; i < 255; i++) begin
            do_rel(1, 2, 0, 256);
            do_tlp(1, 2, 256);
        end
        do_rel(1, 2, 0, 16'h00E0);
        do_tlp(1, 2, 16'h00E0);
        do_tlp(1, 2, 32);
        do_rel(1, 2, 0, 32);
        do_tlp(1, 2, 32);

        // Same-cycle release and TLP at header limit.
        do_init(0, 2, 2, 0, 0, 0);
        do_tlp(0, 2, 0);
        do_tlp(0, 2, 0);
        release_valid = 1; release_vc = 0; release_typ = 2'b10; release_hdr_creds = 2;
        tlp_valid = 1; tlp_vc = 0; tlp_typ = 2'b10;
        tick();
        do_tlp(0, 2, 0);
        do_tlp(0, 2, 0);
        do_tlp(0, 2, 0);

        // Init collides with TLP on the same slot; reserved type ignored.
        init_valid = 1; init_vc = 0; init_typ = 2'b00; init_hdr_creds = 1; init_data_creds = 1;
        tlp_valid = 1; tlp_vc = 0; tlp_typ = 2'b00;
        tick();
        do_tlp(0, 3, 5);
        do_init(0, 3, 5, 5, 0, 0);

        // Reporting disabled over an overflow, then async reset mid-stream.
        do_reset();
        flow_control_en = 0;
        do_init(0, 0, 1, 0, 0, 0);
        do_init(0, 1, 1, 0, 0, 0);
        do_init(0, 2, 1, 0, 0, 0);
        do_tlp(0, 0, 0);
        do_tlp(0, 0, 0);
        flow_control_en = 1;
        do_rel(0, 0, 1, 0);
        do_tlp(0, 0, 0);
        do_tlp(1, 1, 0);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            flow_control_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 8) begin
                init_valid = 1; init_vc = VC_W'($urandom_range(0, NUM_VC - 1));
                init_typ = 2'($urandom_range(0, 3));
                init_hdr_creds = HW'(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40));
                init_data_creds = DW'(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 300));
                init_hdr_scale = 2'($urandom_range(0, 3));
                init_data_scale = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) < 35) begin
                release_valid = 1; release_vc = VC_W'($urandom_range(0, NUM_VC - 1));
                release_typ = 2'($urandom_range(0, 3));
                release_hdr_creds = HW'($urandom_range(0, 3));
                release_data_creds = DW'($urandom_range(0, 24));
            end
            if ($urandom_range(0, 99) < 50) begin
                tlp_valid = 1; tlp_vc = VC_W'($urandom_range(0, NUM_VC - 1));
                tlp_typ = 2'($urandom_range(0, 3));
                tlp_data_creds = CW'(($urandom_range(0, 19) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 16));
            end
            tick();
            if (n == 1500) do_reset();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_rx_fc_credit_checker.md
Name: tl_rx_fc_credit_checker

Overview:
Stateful receiver-side flow-control checker for the TL RX write path. It is the multi-VC successor to the per-type combinational credit comparator. Per VC and per type (P/NP/CPL) it holds CREDITS_ALLOCATED and CREDITS_RECEIVED counters for headers and data, honours scaled-FC field widths and infinite credits, and flags receiver overflow using PCIe modular arithmetic. It sits between the DLL RX TLP stream and the RX buffer credit-release logic.

Parameters:
NUM_VC, 2, number of virtual channels tracked (1..8)
VC_W, 1, width of VC index (>= clog2(NUM_VC), min 1)
FC_HDR_CREDS_WIDTH, 12, max header counter width (scale 11)
FC_DATA_CREDS_WIDTH, 16, max data counter width (scale 11)
CONS_DATA_WIDTH, 9, data credits consumed per TLP (4096B/16B = 256)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
init_valid  in  1  load advertised credits for one VC/type
init_vc  in  VC_W  VC index
init_typ  in  2  00 P, 01 NP, 10 CPL, 11 ignored
init_hdr_creds  in  FC_HDR_CREDS_WIDTH  initial header credits, raw units (0 = infinite)
init_data_creds  in  FC_DATA_CREDS_WIDTH  initial data credits, raw units (0 = infinite)
init_hdr_scale  in  2  header scale
init_data_scale  in  2  data scale
release_valid  in  1  RX buffer freed credits
release_vc  in  VC_W  VC index
release_typ  in  2  type
release_hdr_creds  in  FC_HDR_CREDS_WIDTH  header credits freed
release_data_creds  in  FC_DATA_CREDS_WIDTH  data credits freed
tlp_valid  in  1  TLP received from DLL
tlp_vc  in  VC_W  VC index
tlp_typ  in  2  type
tlp_data_creds  in  CONS_DATA_WIDTH  data credits consumed; header consumption is always 1
flow_control_en  in  1  error reporting enable
flow_control_error  out  1  one-cycle error pulse
err_sticky  out  1  set on first error, held until reset
err_vc  out  VC_W  VC of first error
err_typ  out  2  type of first error
err_cause  out  2  01 hdr overflow, 10 data overflow, 11 uninitialised VC/type
vc_active  out  NUM_VC  all three types of VC initialised

Behaviour:
- Clock and reset: single clock `clk`. `rst_n` is an asynchronous, active-low reset.
- Reset values: all counters, scales, init flags, infinite flags and outputs are 0.
- Field width W from scale:
  - hdr: 00/01 -> 8, 10 -> 10, 11 -> 12
  - data: 00/01 -> 12, 10 -> 14, 11 -> 16
  - All counter arithmetic is mod 2^W; bits above W are held at 0.
- Init (per slot = VC×type), on init_valid with typ != 11:
  - ALLOC <= init value, RCVD <= 0, scale latched, inf flag <= (value == 0), init flag <= 1. Same rule separately for hdr and data.
  - Re-init of an active slot reloads it the same way. init_typ 11 has no effect.
  - vc_active[v] = AND of the three init flags of VC v, registered (visible the cycle after the third init).
- Release: ALLOC <= ALLOC + release_creds, mod 2^W. No effect on infinite counters or uninitialised slots.
- TLP check, on tlp_valid, slot s, registered:
  - Compute new_rcvd = RCVD + consumed and diff = (ALLOC − new_rcvd) mod 2^W.
  - Overflow when diff[W−1] == 1, i.e. diff >= 2^(W−1). This is evaluated separately for hdr and data; infinite counters are never checked.
  - Slot not initialised -> cause 11. Otherwise data overflow takes priority over hdr overflow for err_cause.
  - Good TLP: RCVD updated at the next edge. Erroneous TLP: RCVD unchanged (TLP discarded).
  - flow_control_error pulses the cycle after tlp_valid, gated by flow_control_en.
  - With enable low, counters update as for a good TLP, no pulse, no sticky.
  - tlp_typ 11 is ignored.
- Simultaneous events on the same slot:
  - init has highest priority; release and TLP in the same cycle are dropped.
  - Release + TLP: the check uses the pre-release ALLOC; both updates are applied.
- Sticky capture: err_vc/err_typ/err_cause latch only on the first error and hold until reset.
- Reset mid-operation clears all state immediately (asynchronous).
- Latency: 1 cycle from tlp_valid to pulse; no backpressure.

Decomposition:
- Package tl_rx_fc_pkg:
  - type codes P/NP/CPL/RSVD and err_cause codes
  - functions hdr_field_w(scale), data_field_w(scale)
  - mask function for mod-2^W
- Sub-module tl_rx_fc_credit_slot: one hdr/data counter pair with init/release/consume and overflow outputs. Instantiated NUM_VC×3 via generate.
- Top level: decode, priority, error capture, vc_active.

Test Plan:
1. Reset, then TLP on VC0/P before init -> pulse next cycle, err_cause=11, err_vc=0, err_typ=00, sticky=1.
2. Init VC1 P hdr=4, data=16, scale 01; send 4 TLPs of 4 data credits -> no error. 5th TLP -> pulse, err_cause=01, RCVD hdr stays 4.
3. Scale 11, data ALLOC=0xFFF0, RCVD=0xFFE0; TLP of 32 credits (new_rcvd=0x0000, diff=0xFFF0, bit15=1) -> data overflow. With a release of 0x20 one cycle earlier -> no error, wrap-around is correct.
4. Init NP with hdr=0 (infinite), data=8; 100 zero-data TLPs -> no error, hdr RCVD stays 0.
5. Same-cycle release(+2 hdr) and TLP on a slot at hdr limit -> error, ALLOC still increments by 2; the next TLP passes.
6. flow_control_en=0 over an overflow -> no pulse, no sticky, RCVD advances. Assert rst_n mid-stream -> all outputs 0 without a clock edge.
